fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Sequencer for the shared coefficient-ROM FIR datapath (LP/HP band filters with a `sequencing` input). It tracks the circular sample queue's write and read pointers and raises `sequencing` for one full convolution window per new audio sample. When the MAC result has settled, it captures the filter's left/right outputs and presents them as one validated sample. It sits between the audio sample source, the queue RAM and one band filter.

Parameters:
TAPS, 1021, filter length; samples per convolution
DEPTH, 1536, circular queue depth in samples; must be > TAPS+1
AW, 11, pointer width; 2**AW >= DEPTH
SEQ_EXTRA, 2, extra sequencing cycles beyond TAPS, covering ROM/RAM read latency
CAP_DLY, 1, cycles between the last sequencing cycle and the capture edge; >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
smpl_vld  in  1  one-cycle pulse; new left/right sample present at the queue write port
filt_rght  in  16  signed filter right output
filt_lft  in  16  signed filter left output
wr_en  out  1  queue write strobe; combinational, equals smpl_vld
wr_ptr  out  AW  queue write address
rd_ptr  out  AW  queue read address
sequencing  out  1  filter run window
rght_out  out  16  captured right result, held between captures
lft_out  out  16  captured left result, held between captures
out_vld  out  1  one-cycle pulse; new result on rght_out/lft_out
full  out  1  queue holds >= TAPS samples
overrun  out  1  sticky; a sample arrived while one was already pending

Behaviour:
- Reset is asynchronous, active-low, clock clk. All registered outputs go to 0: wr_ptr, rd_ptr, sequencing, rght_out, lft_out, out_vld, full, overrun. Sample count = 0, pending = 0, state = IDLE.
- Write side runs independently of the FSM. wr_en = smpl_vld. wr_ptr advances by 1 modulo DEPTH on each smpl_vld edge (DEPTH-1 -> 0).
- Sample count increments per smpl_vld and saturates at TAPS. full = (count == TAPS), registered.
- FSM states: IDLE, SEQ, DONE.
- IDLE -> SEQ: at the edge where smpl_vld=1 and the count after this write is >= TAPS.
  - On that edge, rd_ptr <= (wr_ptr_new - TAPS) mod DEPTH, where wr_ptr_new = wr_ptr + 1 mod DEPTH. This is the oldest sample.
  - smpl_vld while count < TAPS after the write stays in IDLE; the sample is written only.
- SEQ: sequencing = 1 for exactly TAPS+SEQ_EXTRA consecutive cycles.
  - rd_ptr advances by 1 mod DEPTH at every SEQ edge.
  - Cycle counter, width clog2(TAPS+SEQ_EXTRA+1), clears on SEQ entry.
  - Leaves to DONE after the last cycle.
- DONE: lasts CAP_DLY cycles, sequencing = 0.
  - At the edge ending the last DONE cycle: rght_out <= filt_rght, lft_out <= filt_lft, and out_vld is set for the following cycle only.
  - Next state on that edge: SEQ if pending=1 (pending cleared, rd_ptr reloaded as above from the current wr_ptr), else IDLE.
  - sequencing may therefore rise in the same cycle as out_vld.
- Pending: smpl_vld in SEQ or DONE still writes and sets pending.
  - smpl_vld while pending is already 1 sets overrun; overrun clears only on reset.
  - Only one pending request is kept.
- Simultaneous smpl_vld and the DONE exit edge with pending=0: the request is taken as a new start. Next state SEQ, rd_ptr computed from wr_ptr_new.
- The rd_ptr start value is snapshotted at SEQ entry. Writes during SEQ never change the current window.
- Reset mid-SEQ or mid-DONE: sequencing drops immediately, no out_vld, count = 0, and the queue must refill with TAPS samples.
- Output widths are exact. No arithmetic on filter data; capture only.

Decomposition:
- Package fir_seq_pkg holds:
  - the state enum (IDLE, SEQ, DONE)
  - localparam SEQ_LEN = TAPS + SEQ_EXTRA
  - a modulo-DEPTH add/sub function
- One sub-module, circ_ptr: AW-bit modulo-DEPTH pointer with inc, load and load value. Instantiated twice, for write and read.

Test Plan (TAPS=4, DEPTH=8, AW=3, SEQ_EXTRA=2, CAP_DLY=1):
1. Assert rst_n=0 then release -> all outputs 0, sequencing stays 0 for 20 idle cycles.
2. Three smpl_vld pulses 5 cycles apart -> wr_en pulses, wr_ptr 0->1->2->3, full=0, no sequencing. Fourth pulse -> full=1, sequencing high 6 cycles, rd_ptr 0,1,2,3,4,5.
3. Drive filt_rght=16'h1234 and filt_lft=16'hFEDC in the cycle after the last sequencing cycle -> out_vld one cycle later for 1 cycle, rght_out=16'h1234, lft_out=16'hFEDC, held until the next capture.
4. Wrap: total 9 samples, so wr_ptr_new=1 at the 9th -> rd_ptr start = 5, rd_ptr sequence 5,6,7,0,1,2.
5. One smpl_vld mid-SEQ -> sequencing re-rises in the out_vld cycle, overrun=0. Two smpl_vld mid-SEQ -> overrun=1, exactly one extra window runs.
6. rst_n low at SEQ cycle 3 -> sequencing=0 and rd_ptr=0 asynchronously, no out_vld. After release, 3 samples give no sequencing; the 4th starts a window.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR window sequencer.
// Holds the FSM state encoding and modulo pointer arithmetic.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEF_TAPS      = 1021;
    localparam int DEF_DEPTH     = 1536;
    localparam int DEF_AW        = 11;
    localparam int DEF_SEQ_EXTRA = 2;
    localparam int DEF_CAP_DLY   = 1;
    localparam int SEQ_LEN       = DEF_TAPS + DEF_SEQ_EXTRA;

    function automatic int unsigned seq_len(
        input int unsigned taps,
        input int unsigned extra
    );
        return taps + extra;
    endfunction

    // Operands are assumed already reduced, so one conditional fold suffices.
    function automatic int unsigned mod_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned depth
    );
        int unsigned s;
        s = a + b;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

    function automatic int unsigned mod_sub(
        input int unsigned a,
        input int unsigned b,
        input int unsigned depth
    );
        return (a >= b) ? (a - b) : (a + depth - b);
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Bundle between sample source, queue RAM, band filter and sequencer.
// The slave side is the sequencer; the master side is its environment.
interface fir_seq_ctrl_if #(
    parameter int AW = 11
);
    logic          smpl_vld;
    logic [15:0]   filt_rght;
    logic [15:0]   filt_lft;
    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          sequencing;
    logic [15:0]   rght_out;
    logic [15:0]   lft_out;
    logic          out_vld;
    logic          full;
    logic          overrun;

    modport master (
        output smpl_vld, filt_rght, filt_lft,
        input  wr_en, wr_ptr, rd_ptr, sequencing,
        input  rght_out, lft_out, out_vld, full, overrun
    );

    modport slave (
        input  smpl_vld, filt_rght, filt_lft,
        output wr_en, wr_ptr, rd_ptr, sequencing,
        output rght_out, lft_out, out_vld, full, overrun
    );
endinterface

// File: rtl/fir_seq_ctrl_circ_ptr.sv
// Modulo-DEPTH address pointer with increment and parallel load.
// Load wins over increment.
module circ_ptr
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= AW'(mod_add(32'(ptr), 32'd1, unsigned'(DEPTH)));
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Window sequencer for the shared-ROM FIR: tracks queue pointers, runs one
// convolution window per sample and captures the settled filter result.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int TAPS      = DEF_TAPS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = DEF_AW,
    parameter int SEQ_EXTRA = DEF_SEQ_EXTRA,
    parameter int CAP_DLY   = DEF_CAP_DLY
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_seq_ctrl_if.slave bus
);

    localparam int SEQ_N = int'(seq_len(TAPS, SEQ_EXTRA));
    localparam int SW    = $clog2(SEQ_N + 1);
    localparam int DW    = $clog2(CAP_DLY + 1);
    localparam int CW    = $clog2(TAPS + 1);

    seq_state_t    state, state_n;
    logic [SW-1:0] seq_cnt, seq_n;
    logic [DW-1:0] dly_cnt, dly_n;
    logic [CW-1:0] count, cnt_n;
    logic          pending, pend_n;
    logic          overrun, ovr_n;
    logic          start, cap;
    logic          out_vld, full;
    logic [15:0]   rght_q, lft_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_new, base, rd_start;

    assign wr_new   = AW'(mod_add(32'(wr_ptr), 32'd1, unsigned'(DEPTH)));
    assign base     = bus.smpl_vld ? wr_new : wr_ptr;
    assign rd_start = AW'(mod_sub(32'(base), unsigned'(TAPS), unsigned'(DEPTH)));
    assign cnt_n    = (bus.smpl_vld && count != CW'(TAPS)) ? count + 1'b1 : count;

    circ_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (bus.smpl_vld),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    // Start value is loaded once per window; later writes never move it.
    circ_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (state == SEQ),
        .load     (start),
        .load_val (rd_start),
        .ptr      (rd_ptr)
    );

    always_comb begin
        state_n = state;
        seq_n   = seq_cnt;
        dly_n   = dly_cnt;
        pend_n  = pending;
        ovr_n   = overrun;
        start   = 1'b0;
        cap     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.smpl_vld && cnt_n == CW'(TAPS)) start = 1'b1;
            end
            SEQ: begin
                seq_n = seq_cnt + 1'b1;
                if (seq_cnt == SW'(SEQ_N - 1)) begin
                    state_n = DONE;
                    dly_n   = '0;
                end
            end
            DONE: begin
                dly_n = dly_cnt + 1'b1;
                if (dly_cnt == DW'(CAP_DLY - 1)) begin
                    cap     = 1'b1;
                    state_n = IDLE;
                    if (pending || bus.smpl_vld) start = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = SEQ;
            seq_n   = '0;
            pend_n  = 1'b0;
        end
        // A sample during a busy window queues one request; a second overruns.
        if (bus.smpl_vld && state != IDLE) begin
            if (pending) ovr_n = 1'b1;
            if (!start)  pend_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            seq_cnt <= '0;
            dly_cnt <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
            full    <= 1'b0;
            out_vld <= 1'b0;
            rght_q  <= '0;
            lft_q   <= '0;
        end else begin
            state   <= state_n;
            seq_cnt <= seq_n;
            dly_cnt <= dly_n;
            pending <= pend_n;
            overrun <= ovr_n;
            count   <= cnt_n;
            full    <= (cnt_n == CW'(TAPS));
            out_vld <= cap;
            if (cap) begin
                rght_q <= bus.filt_rght;
                lft_q  <= bus.filt_lft;
            end
        end
    end

    assign bus.wr_en      = bus.smpl_vld;
    assign bus.wr_ptr     = wr_ptr;
    assign bus.rd_ptr     = rd_ptr;
    assign bus.sequencing = (state == SEQ);
    assign bus.rght_out   = rght_q;
    assign bus.lft_out    = lft_q;
    assign bus.out_vld    = out_vld;
    assign bus.full       = full;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with TAPS=4, DEPTH=8, AW=3.
// Expected window starts and captures are queued; monitors pop and compare.
module tb_fir_seq_ctrl;

    localparam int TAPS  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int SEQL  = 6;

    logic clk;
    logic rst_n;

    fir_seq_ctrl_if #(.AW(AW)) bus();

    fir_seq_ctrl #(
        .TAPS(TAPS), .DEPTH(DEPTH), .AW(AW), .SEQ_EXTRA(2), .CAP_DLY(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          exp_win[$];
    logic [31:0] exp_out[$];

    int          in_win = 0;
    int          wlen   = 0;
    int          wstart = 0;
    logic [15:0] last_r = '0;
    logic [15:0] last_l = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Window and output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_win = 0;
                last_r = '0;
                last_l = '0;
            end else begin
                if (bus.sequencing) begin
                    if (in_win == 0) begin
                        in_win = 1;
                        wlen   = 0;
                        if (exp_win.size() == 0) begin
                            chk("win_unexpected", 32'd1, 32'd0);
                            wstart = 0;
                        end else begin
                            wstart = exp_win.pop_front();
                        end
                    end
                    chk("rd_ptr", 32'(bus.rd_ptr), 32'((wstart + wlen) % DEPTH));
                    wlen++;
                end else if (in_win != 0) begin
                    in_win = 0;
                    chk("win_len", 32'(wlen), 32'(SEQL));
                end
                if (bus.out_vld) begin
                    if (exp_out.size() == 0) begin
                        chk("out_unexpected", 32'd1, 32'd0);
                    end else begin
                        logic [31:0] e;
                        e = exp_out.pop_front();
                        chk("capture", {bus.rght_out, bus.lft_out}, e);
                        last_r = e[31:16];
                        last_l = e[15:0];
                    end
                end else begin
                    chk("hold", {bus.rght_out, bus.lft_out}, {last_r, last_l});
                end
            end
        end
    end

    // Filter model: new result appears in the cycle after the last run cycle
    initial begin
        logic prev_seq;
        int   k;
        logic [15:0] r, l;
        prev_seq = 1'b0;
        k = 0;
        bus.filt_rght = '0;
        bus.filt_lft  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_seq && !bus.sequencing) begin
                r = 16'h1234 + 16'(k * 16'h0111);
                l = 16'hFEDC - 16'(k * 16'h0101);
                bus.filt_rght = r;
                bus.filt_lft  = l;
                exp_out.push_back({r, l});
                k++;
            end
            prev_seq = rst_n ? bus.sequencing : 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.smpl_vld = 1'b1;
        #1 chk("wr_en_hi", 32'(bus.wr_en), 32'd1);
        @(posedge clk);
        #1 bus.smpl_vld = 1'b0;
        chk("wr_en_lo", 32'(bus.wr_en), 32'd0);
    endtask

    initial begin
        int starts[5];
        int got;
        starts = '{1, 2, 3, 4, 5};
        rst_n = 1'b0;
        bus.smpl_vld = 1'b0;
        #2;
        chk("rst_outs",
            {21'd0, bus.wr_ptr, bus.rd_ptr, bus.sequencing, bus.out_vld,
             bus.full, bus.overrun, 1'b0},
            32'd0);
        chk("rst_data", {bus.rght_out, bus.lft_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(20);
        chk("idle_seq", 32'(bus.sequencing), 32'd0);

        // Fill the queue
        pulse(); chk("wr_ptr1", 32'(bus.wr_ptr), 32'd1); chk("full1", 32'(bus.full), 32'd0);
        idle(4);
        pulse(); chk("wr_ptr2", 32'(bus.wr_ptr), 32'd2); chk("full2", 32'(bus.full), 32'd0);
        idle(4);
        pulse(); chk("wr_ptr3", 32'(bus.wr_ptr), 32'd3); chk("full3", 32'(bus.full), 32'd0);
        chk("seq_fill", 32'(bus.sequencing), 32'd0);
        idle(4);
        exp_win.push_back(0);
        pulse(); chk("wr_ptr4", 32'(bus.wr_ptr), 32'd4); chk("full4", 32'(bus.full), 32'd1);
        idle(12);

        // Samples 5..9, the last one wraps the write pointer
        for (int i = 0; i < 5; i++) begin
            exp_win.push_back(starts[i]);
            pulse();
            idle(10);
        end
        chk("wr_ptr_wrap", 32'(bus.wr_ptr), 32'd1);

        // One sample during a window: back-to-back rerun
        exp_win.push_back(6);
        pulse();
        idle(2);
        exp_win.push_back(7);
        pulse();
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (bus.out_vld) got = 1;
        end
        chk("ovld_seen", 32'(got), 32'd1);
        chk("seq_at_ovld", 32'(bus.sequencing), 32'd1);
        idle(14);
        chk("overrun0", 32'(bus.overrun), 32'd0);

        // Two samples during a window: one rerun, overrun latched
        exp_win.push_back(0);
        pulse();
        idle(2);
        exp_win.push_back(2);
        pulse();
        idle(1);
        pulse();
        chk("overrun1", 32'(bus.overrun), 32'd1);
        idle(25);
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Reset in the third run cycle
        exp_win.push_back(3);
        pulse();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_seq", 32'(bus.sequencing), 32'd0);
        chk("rst_rd", 32'(bus.rd_ptr), 32'd0);
        chk("rst_misc",
            {28'd0, bus.wr_ptr == 3'd0, bus.out_vld, bus.full, bus.overrun},
            32'h8);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            pulse();
            idle(3);
        end
        chk("refill_full", 32'(bus.full), 32'd0);
        chk("refill_seq", 32'(bus.sequencing), 32'd0);
        exp_win.push_back(0);
        pulse();
        chk("refill_full4", 32'(bus.full), 32'd1);
        idle(12);

        chk("win_left", 32'(exp_win.size()), 32'd0);
        chk("out_left", 32'(exp_out.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
